// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants, controller state encoding and small helpers
// used by the initiator and its read-data aligner.
package ahb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  // Natural alignment check; sizes above a word are never legal.
  function automatic logic access_legal(input logic [1:0] addr_lo, input logic [2:0] size);
    logic ok;
    case (size)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = (addr_lo[0] == 1'b0);
      HSIZE_WORD: ok = (addr_lo == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [DATA_W-1:0] replicate_wdata(input logic [DATA_W-1:0] wdata,
                                                        input logic [2:0] size);
    logic [DATA_W-1:0] lanes;
    case (size)
      HSIZE_BYTE: lanes = {4{wdata[7:0]}};
      HSIZE_HALF: lanes = {2{wdata[15:0]}};
      HSIZE_WORD: lanes = wdata;
      default:    lanes = {DATA_W{1'b0}};
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/ahb_master_ctrl_if.sv
// Request/response port of the local requester plus the AHB-Lite bus,
// seen from the initiator (master) or from the requester/slave side.
interface ahb_master_ctrl_if;
  import ahb_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [2:0]        cmd_size;
  logic              cmd_signed;
  logic [3:0]        cmd_prot;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata;
  logic              hready;
  logic              hresp;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_signed, cmd_prot, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_signed, cmd_prot, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
    output hrdata, hready, hresp
  );

endinterface

// File: rtl/ahb_rdata_align.sv
// Picks the addressed byte/halfword lane out of hrdata and extends it to
// 32 bits, sign- or zero-filled as the requester asked.
module ahb_rdata_align
  import ahb_pkg::*;
(
  input  logic [DATA_W-1:0] hrdata,
  input  logic [1:0]        addr_lo,
  input  logic [2:0]        size,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] rdata
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection and extension
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    case (addr_lo)
      2'b00:   byte_s = hrdata[7:0];
      2'b01:   byte_s = hrdata[15:8];
      2'b10:   byte_s = hrdata[23:16];
      2'b11:   byte_s = hrdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo[1]) begin
      half_s = hrdata[31:16];
    end else begin
      half_s = hrdata[15:0];
    end
    case (size)
      HSIZE_BYTE: rdata = {{24{sign_ext & byte_s[7]}}, byte_s};
      HSIZE_HALF: rdata = {{16{sign_ext & half_s[15]}}, half_s};
      HSIZE_WORD: rdata = hrdata;
      default:    rdata = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/ahb_master_ctrl.sv
// Single-outstanding AHB-Lite initiator: one request becomes one NONSEQ
// SINGLE transfer; every bus and response output is driven from a flop.
module ahb_master_ctrl
  import ahb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  ahb_master_ctrl_if.master bus
);

  state_e            state_r, state_nxt_s;
  logic              cmd_write_r, cmd_signed_r;
  logic [ADDR_W-1:0] cmd_addr_r;
  logic [2:0]        cmd_size_r;
  logic [3:0]        cmd_prot_r;
  logic [DATA_W-1:0] cmd_wdata_r;
  logic              err_r, err_nxt_s;
  logic              accept_s, legal_s;
  logic [DATA_W-1:0] rdata_ext_s;

  logic              cmd_ready_r, cmd_ready_nxt_s;
  logic              rsp_valid_r, rsp_valid_nxt_s;
  logic              rsp_err_r, rsp_err_nxt_s;
  logic [DATA_W-1:0] rsp_rdata_r, rsp_rdata_nxt_s;
  logic [1:0]        htrans_r, htrans_nxt_s;
  logic [ADDR_W-1:0] haddr_r, haddr_nxt_s;
  logic              hwrite_r, hwrite_nxt_s;
  logic [2:0]        hsize_r, hsize_nxt_s;
  logic [3:0]        hprot_r, hprot_nxt_s;
  logic [DATA_W-1:0] hwdata_r, hwdata_nxt_s;

  assign accept_s = (state_r == ST_IDLE) && bus.cmd_valid;
  assign legal_s  = access_legal(bus.cmd_addr[1:0], bus.cmd_size);

  ahb_rdata_align u_rdata_align (
    .hrdata   (bus.hrdata),
    .addr_lo  (cmd_addr_r[1:0]),
    .size     (cmd_size_r),
    .sign_ext (cmd_signed_r),
    .rdata    (rdata_ext_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; illegal requests skip the bus and answer at once
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          state_nxt_s = legal_s ? ST_ADDR : ST_RESP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ADDR: state_nxt_s = bus.hready ? ST_DATA : ST_ADDR;
      ST_DATA: state_nxt_s = bus.hready ? ST_RESP : ST_DATA;
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; an hresp seen in any data-phase
  // cycle (including the first, non-ready one) sticks until completion.
  always_comb begin
    haddr_nxt_s  = haddr_r;
    hwrite_nxt_s = hwrite_r;
    hsize_nxt_s  = hsize_r;
    hprot_nxt_s  = hprot_r;
    hwdata_nxt_s = hwdata_r;
    err_nxt_s    = err_r;
    if (accept_s) begin
      err_nxt_s = ~legal_s;
      if (legal_s) begin
        haddr_nxt_s  = bus.cmd_addr;
        hwrite_nxt_s = bus.cmd_write;
        hsize_nxt_s  = bus.cmd_size;
        hprot_nxt_s  = bus.cmd_prot;
      end else begin
        haddr_nxt_s  = haddr_r;
      end
    end else if (state_r == ST_DATA) begin
      err_nxt_s = err_r | (bus.hresp == HRESP_ERROR);
    end else begin
      err_nxt_s = err_r;
    end
    if ((state_r == ST_ADDR) && bus.hready) begin
      hwdata_nxt_s = cmd_write_r ? replicate_wdata(cmd_wdata_r, cmd_size_r) : {DATA_W{1'b0}};
    end else begin
      hwdata_nxt_s = hwdata_r;
    end
    if ((state_r == ST_DATA) && bus.hready && !cmd_write_r && !err_nxt_s) begin
      rsp_rdata_nxt_s = rdata_ext_s;
    end else begin
      rsp_rdata_nxt_s = {DATA_W{1'b0}};
    end
    cmd_ready_nxt_s = (state_nxt_s == ST_IDLE);
    rsp_valid_nxt_s = (state_nxt_s == ST_RESP);
    rsp_err_nxt_s   = (state_nxt_s == ST_RESP) && err_nxt_s;
    htrans_nxt_s    = (state_nxt_s == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  end

  // Output and error-flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
      htrans_r    <= HTRANS_IDLE;
      haddr_r     <= {ADDR_W{1'b0}};
      hwrite_r    <= 1'b0;
      hsize_r     <= HSIZE_BYTE;
      hprot_r     <= 4'b0000;
      hwdata_r    <= {DATA_W{1'b0}};
      err_r       <= 1'b0;
    end else begin
      cmd_ready_r <= cmd_ready_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      rsp_err_r   <= rsp_err_nxt_s;
      rsp_rdata_r <= rsp_rdata_nxt_s;
      htrans_r    <= htrans_nxt_s;
      haddr_r     <= haddr_nxt_s;
      hwrite_r    <= hwrite_nxt_s;
      hsize_r     <= hsize_nxt_s;
      hprot_r     <= hprot_nxt_s;
      hwdata_r    <= hwdata_nxt_s;
      err_r       <= err_nxt_s;
    end
  end

  // Latched copy of the accepted request
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_write_r  <= 1'b0;
      cmd_signed_r <= 1'b0;
      cmd_addr_r   <= {ADDR_W{1'b0}};
      cmd_size_r   <= HSIZE_BYTE;
      cmd_prot_r   <= 4'b0000;
      cmd_wdata_r  <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      cmd_write_r  <= bus.cmd_write;
      cmd_signed_r <= bus.cmd_signed;
      cmd_addr_r   <= bus.cmd_addr;
      cmd_size_r   <= bus.cmd_size;
      cmd_prot_r   <= bus.cmd_prot;
      cmd_wdata_r  <= bus.cmd_wdata;
    end else begin
      cmd_write_r  <= cmd_write_r;
    end
  end

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.htrans    = htrans_r;
  assign bus.haddr     = haddr_r;
  assign bus.hwrite    = hwrite_r;
  assign bus.hsize     = hsize_r;
  assign bus.hburst    = HBURST_SINGLE;
  assign bus.hprot     = hprot_r;
  assign bus.hwdata    = hwdata_r;

endmodule

// File: tb/tb_ahb_master_ctrl.sv
// Self-checking bench for ahb_master_ctrl: directed scenarios plus random
// transfers against a lane/latency reference model; the bench plays the slave.
module tb_ahb_master_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  ahb_master_ctrl_if bus ();

  ahb_master_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Observations from the last transfer
  int          obs_nonseq, obs_rsp_k, obs_rsp_cnt, obs_ready_k;
  logic        obs_busy_ready, obs_ctrl_changed, obs_hwdata_changed;
  logic [31:0] obs_haddr, obs_hwdata, obs_rdata;
  logic [2:0]  obs_hsize;
  logic [3:0]  obs_hprot;
  logic        obs_hwrite, obs_err;

  // Reference model
  function automatic logic m_legal(input logic [31:0] a, input logic [2:0] s);
    if (s > 3'd2) return 1'b0;
    return (a % (32'd1 << s)) == 32'd0;
  endfunction

  function automatic logic [31:0] m_hwdata(input logic [31:0] w, input logic [2:0] s);
    if (s == 3'd0) return (w & 32'hFF) * 32'h0101_0101;
    if (s == 3'd1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] d, input logic [31:0] a,
                                          input logic [2:0] s, input logic sg);
    logic [31:0] v;
    if (s == 3'd0) begin
      v = (d >> (32'(a % 32'd4) * 32'd8)) & 32'hFF;
      if (sg && v >= 32'd128) v = v - 32'd256;
    end else if (s == 3'd1) begin
      v = (d >> (32'((a / 32'd2) % 32'd2) * 32'd16)) & 32'hFFFF;
      if (sg && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = d;
    end
    return v;
  endfunction

  // Issues one request and plays the slave: wa/wd wait states in the
  // address/data phases, error response on the last two data cycles.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic sg, input logic [31:0] wdata, input logic [3:0] prot,
                         input int wa, input int wd, input logic [31:0] rdat, input logic err);
    obs_nonseq = 0; obs_rsp_k = -1; obs_rsp_cnt = 0; obs_ready_k = -1;
    obs_busy_ready = 1'b0; obs_ctrl_changed = 1'b0; obs_hwdata_changed = 1'b0;
    obs_rdata = 32'h0; obs_err = 1'b0; obs_hwdata = 32'h0;
    for (int i = 0; i < 20 && bus.cmd_ready !== 1'b1; i++) @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_size = size;
    bus.cmd_signed = sg; bus.cmd_wdata = wdata; bus.cmd_prot = prot;
    bus.hready = 1'b1; bus.hresp = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_wdata = $urandom();
    for (int c = 0; c < 60; c++) begin
      if (bus.htrans == 2'b10) begin
        if (obs_nonseq == 0) begin
          obs_haddr = bus.haddr; obs_hsize = bus.hsize;
          obs_hwrite = bus.hwrite; obs_hprot = bus.hprot;
        end else if ({bus.haddr, bus.hsize, bus.hwrite, bus.hprot} !==
                     {obs_haddr, obs_hsize, obs_hwrite, obs_hprot}) begin
          obs_ctrl_changed = 1'b1;
        end
        obs_nonseq++;
      end
      if (c == wa + 1) obs_hwdata = bus.hwdata;
      if (c > wa + 1 && c <= wa + 1 + wd && bus.hwdata !== obs_hwdata) obs_hwdata_changed = 1'b1;
      if (bus.rsp_valid === 1'b1) begin
        obs_rsp_cnt++;
        if (obs_rsp_k < 0) begin
          obs_rsp_k = c; obs_rdata = bus.rsp_rdata; obs_err = bus.rsp_err;
        end
      end
      if (bus.cmd_ready === 1'b1) begin
        if (obs_rsp_k < 0 || c == obs_rsp_k) obs_busy_ready = 1'b1;
        else if (obs_ready_k < 0) obs_ready_k = c;
      end
      if (c < wa) bus.hready = 1'b0;
      else if (c == wa) bus.hready = 1'b1;
      else if (c < wa + 1 + wd) bus.hready = 1'b0;
      else bus.hready = 1'b1;
      bus.hresp  = err && (c > wa) && (c == wa + wd || c == wa + wd + 1);
      bus.hrdata = (c > wa) ? rdat : $urandom();
      if (obs_rsp_k >= 0 && c >= obs_rsp_k + 2) break;
      @(negedge clk);
    end
    bus.hready = 1'b1; bus.hresp = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h0; bus.cmd_size = 3'd0;
    bus.cmd_signed = 1'b0; bus.cmd_prot = 4'h0; bus.cmd_wdata = 32'h0;
    bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.htrans, bus.haddr,
         bus.hwrite, bus.hsize, bus.hburst, bus.hprot, bus.hwdata} !== {1'b1, 111'b0}) begin
      tests_failed++;
      $display("FAIL reset_values got ready=%b rv=%b htrans=%b haddr=%h hwdata=%h want ready=1, all others 0",
               bus.cmd_ready, bus.rsp_valid, bus.htrans, bus.haddr, bus.hwdata);
    end
  endtask

  task automatic test_word_write();
    run_txn(1'b1, 32'h0000_0010, 3'b010, 1'b0, 32'hDEAD_BEEF, 4'h3, 0, 0, 32'h0, 1'b0);
    tests_run++;
    if (obs_nonseq !== 1 || obs_haddr !== 32'h10 || obs_hwrite !== 1'b1 || obs_hsize !== 3'b010 || obs_hprot !== 4'h3) begin
      tests_failed++;
      $display("FAIL word_write_addr got nonseq=%0d haddr=%h hw=%b hsize=%b hprot=%h want 1/00000010/1/010/3",
               obs_nonseq, obs_haddr, obs_hwrite, obs_hsize, obs_hprot);
    end
    tests_run++;
    if (obs_hwdata !== 32'hDEAD_BEEF) begin
      tests_failed++; $display("FAIL word_write_hwdata got %h want deadbeef", obs_hwdata);
    end
    tests_run++;
    if (obs_rsp_k + 1 !== 3 || obs_err !== 1'b0 || obs_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL word_write_rsp got lat=%0d err=%b rdata=%h want 3/0/0", obs_rsp_k + 1, obs_err, obs_rdata);
    end
  endtask

  task automatic test_byte_read();
    run_txn(1'b0, 32'h0000_0003, 3'b000, 1'b1, 32'h0, 4'h0, 0, 0, 32'h80FF_0000, 1'b0);
    tests_run++;
    if (obs_rdata !== 32'hFFFF_FF80 || obs_err !== 1'b0) begin
      tests_failed++; $display("FAIL byte_read_signed got %h err=%b want ffffff80", obs_rdata, obs_err);
    end
    run_txn(1'b0, 32'h0000_0003, 3'b000, 1'b0, 32'h0, 4'h0, 0, 0, 32'h80FF_0000, 1'b0);
    tests_run++;
    if (obs_rdata !== 32'h0000_0080) begin
      tests_failed++; $display("FAIL byte_read_unsigned got %h want 00000080", obs_rdata);
    end
  endtask

  task automatic test_half_write_waits();
    run_txn(1'b1, 32'h0000_0002, 3'b001, 1'b0, 32'h0000_1234, 4'h1, 2, 2, 32'h0, 1'b0);
    tests_run++;
    if (obs_hsize !== 3'b001 || obs_hwdata !== 32'h1234_1234 || obs_hwdata_changed !== 1'b0) begin
      tests_failed++;
      $display("FAIL half_write_data got hsize=%b hwdata=%h chg=%b want 001/12341234/0", obs_hsize, obs_hwdata, obs_hwdata_changed);
    end
    tests_run++;
    if (obs_rsp_k + 1 !== 7 || obs_nonseq !== 3 || obs_ctrl_changed !== 1'b0) begin
      tests_failed++;
      $display("FAIL half_write_waits got lat=%0d nonseq=%0d chg=%b want 7/3/0", obs_rsp_k + 1, obs_nonseq, obs_ctrl_changed);
    end
  endtask

  task automatic test_slave_error();
    int extra_nonseq;
    run_txn(1'b0, 32'h0000_0040, 3'b010, 1'b0, 32'h0, 4'h0, 0, 1, 32'h1234_5678, 1'b1);
    tests_run++;
    if (obs_err !== 1'b1 || obs_rdata !== 32'h0 || obs_rsp_k + 1 !== 4 || obs_rsp_cnt !== 1) begin
      tests_failed++;
      $display("FAIL slave_error got err=%b rdata=%h lat=%0d pulses=%0d want 1/0/4/1", obs_err, obs_rdata, obs_rsp_k + 1, obs_rsp_cnt);
    end
    extra_nonseq = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.htrans == 2'b10) extra_nonseq++;
    end
    tests_run++;
    if (obs_nonseq + extra_nonseq !== 1) begin
      tests_failed++; $display("FAIL slave_error_nonseq got %0d NONSEQ cycles want 1", obs_nonseq + extra_nonseq);
    end
  endtask

  task automatic test_misaligned();
    run_txn(1'b0, 32'h0000_0006, 3'b010, 1'b0, 32'h0, 4'h0, 0, 0, 32'hFFFF_FFFF, 1'b0);
    tests_run++;
    if (obs_nonseq !== 0 || obs_rsp_k + 1 !== 1 || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL misaligned got nonseq=%0d lat=%0d err=%b rdata=%h want 0/1/1/0", obs_nonseq, obs_rsp_k + 1, obs_err, obs_rdata);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    for (int i = 0; i < 20 && bus.cmd_ready !== 1'b1; i++) @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 32'h0000_0020;
    bus.cmd_size = 3'b010; bus.cmd_wdata = 32'hA5A5_5A5A; bus.cmd_prot = 4'hF;
    bus.hready = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    bus.hready = 1'b0;
    tests_run++;
    if (bus.hwdata !== 32'hA5A5_5A5A || bus.cmd_ready !== 1'b0) begin
      tests_failed++; $display("FAIL reset_mid_data got hwdata=%h ready=%b want a5a55a5a/0", bus.hwdata, bus.cmd_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.hready = 1'b1;
    tests_run++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.htrans, bus.haddr,
         bus.hwrite, bus.hsize, bus.hburst, bus.hprot, bus.hwdata} !== {1'b1, 111'b0}) begin
      tests_failed++;
      $display("FAIL reset_mid_values got ready=%b rv=%b haddr=%h hprot=%h hwdata=%h want ready=1, all others 0",
               bus.cmd_ready, bus.rsp_valid, bus.haddr, bus.hprot, bus.hwdata);
    end
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses !== 0 || bus.cmd_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_mid_drop got pulses=%0d ready=%b want 0/1", pulses, bus.cmd_ready);
    end
  endtask

  task automatic test_random();
    logic        wr, sg, err, legal;
    logic [31:0] addr, wdata, rdat, exp_rdata;
    logic [2:0]  size;
    logic [3:0]  prot;
    int          wa, wd, exp_lat;
    for (int n = 0; n < 40; n++) begin
      wr    = 1'($urandom_range(0, 1));
      sg    = 1'($urandom_range(0, 1));
      size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      addr  = $urandom() & 32'h0000_0FFF;
      wdata = $urandom();
      rdat  = $urandom();
      prot  = 4'($urandom_range(0, 15));
      wa    = $urandom_range(0, 3);
      wd    = $urandom_range(0, 3);
      legal = m_legal(addr, size);
      err   = legal && (wd > 0) && ($urandom_range(0, 3) == 0);
      run_txn(wr, addr, size, sg, wdata, prot, wa, wd, rdat, err);
      exp_lat   = legal ? 3 + wa + wd : 1;
      exp_rdata = (!legal || err || wr) ? 32'h0 : m_rdata(rdat, addr, size, sg);
      tests_run++;
      if (obs_rsp_k + 1 !== exp_lat || obs_rsp_cnt !== 1 || obs_ready_k !== obs_rsp_k + 1 || obs_busy_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL rand%0d_timing got lat=%0d pulses=%0d ready_k=%0d busy=%b want lat=%0d pulses=1 ready_k=%0d busy=0",
                 n, obs_rsp_k + 1, obs_rsp_cnt, obs_ready_k, obs_busy_ready, exp_lat, exp_lat);
      end
      tests_run++;
      if (obs_err !== (!legal || err) || obs_rdata !== exp_rdata) begin
        tests_failed++;
        $display("FAIL rand%0d_rsp got err=%b rdata=%h want err=%b rdata=%h (addr=%h size=%0d sg=%b)",
                 n, obs_err, obs_rdata, !legal || err, exp_rdata, addr, size, sg);
      end
      tests_run++;
      if (obs_nonseq !== (legal ? wa + 1 : 0)) begin
        tests_failed++; $display("FAIL rand%0d_nonseq got %0d want %0d", n, obs_nonseq, legal ? wa + 1 : 0);
      end
      if (legal) begin
        tests_run++;
        if (obs_haddr !== addr || obs_hsize !== size || obs_hwrite !== wr || obs_hprot !== prot || obs_ctrl_changed !== 1'b0) begin
          tests_failed++;
          $display("FAIL rand%0d_ctrl got haddr=%h hsize=%0d hw=%b hprot=%h chg=%b want %h/%0d/%b/%h/0",
                   n, obs_haddr, obs_hsize, obs_hwrite, obs_hprot, obs_ctrl_changed, addr, size, wr, prot);
        end
      end
      if (legal && wr) begin
        tests_run++;
        if (obs_hwdata !== m_hwdata(wdata, size) || obs_hwdata_changed !== 1'b0) begin
          tests_failed++;
          $display("FAIL rand%0d_hwdata got %h chg=%b want %h", n, obs_hwdata, obs_hwdata_changed, m_hwdata(wdata, size));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_write();
    test_byte_read();
    test_half_write_waits();
    test_slave_error();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
